// File: rtl/mul_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_add_pkg
// Description : Shared constants and state type for the mul_add block.
// Revision    : 1.0
// ============================================================================
package mul_add_pkg;

    localparam int c_WIDTH_DEFAULT = 32;
    localparam int c_CNT_W_DEFAULT = 6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage : mul_add_pkg
`default_nettype wire

// File: rtl/mul_add_if.sv
`default_nettype none
// ============================================================================
// Module      : mul_add_if
// Description : Start strobe, operands and result/status bundle of mul_add.
// Revision    : 1.0
// ============================================================================
interface mul_add_if
    import mul_add_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT
) ();

    logic             en;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] p_hi;
    logic [WIDTH-1:0] p_lo;
    logic             busy;
    logic             done;

    modport master (
        output en, a, b, c,
        input  p_hi, p_lo, busy, done
    );

    modport slave (
        input  en, a, b, c,
        output p_hi, p_lo, busy, done
    );

endinterface : mul_add_if
`default_nettype wire

// File: rtl/mul_add.sv
`default_nettype none
// ============================================================================
// Module      : mul_add
// Description : Sequential radix-2 shift-add unsigned multiply-accumulate,
//               P = a*b + c, one multiplier bit per clock.
// Revision    : 1.0
// ============================================================================
module mul_add
    import mul_add_pkg::*;
#(
    parameter int WIDTH = c_WIDTH_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    mul_add_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_ONE  = CNT_W'(1);

    state_t             r_state;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_p_hi;
    logic [WIDTH-1:0]   r_p_lo;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] w_acc_next;

    // The addend seeds the accumulator, so no final add is needed; the sum
    // can never exceed 2^(2W) - 2^W, so the 2W-bit add has no carry out.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_p_hi   <= '0;
            r_p_lo   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (bus.en) begin
            // A start always wins, discarding any operation in flight.
            r_acc    <= {{WIDTH{1'b0}}, bus.c};
            r_mcand  <= {{WIDTH{1'b0}}, bus.a};
            r_mplier <= bus.b;
            r_cnt    <= '0;
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + c_ONE;
                    if (r_cnt == c_LAST) begin
                        r_p_hi  <= w_acc_next[2*WIDTH-1:WIDTH];
                        r_p_lo  <= w_acc_next[WIDTH-1:0];
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.p_hi = r_p_hi;
    assign bus.p_lo = r_p_lo;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule : mul_add
`default_nettype wire

// File: tb/tb_mul_add.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_add
// Description : Self-checking bench for mul_add against a cycle-level model.
// Revision    : 1.0
// ============================================================================
module tb_mul_add;

    localparam int W = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    mul_add_if #(.WIDTH(W)) bus ();

    mul_add #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%h required=0x%h", name, act, exp);
    endtask

    // Model: an operation finishes W edges after its start edge with a*b+c.
    logic        m_active = 1'b0;
    int          m_remain = 0;
    logic [63:0] m_pend   = '0;
    logic [63:0] m_p      = '0;
    logic        m_busy   = 1'b0;
    logic        m_done   = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_remain <= 0;
            m_pend   <= '0;
            m_p      <= '0;
            m_busy   <= 1'b0;
            m_done   <= 1'b0;
        end else if (bus.en) begin
            m_active <= 1'b1;
            m_remain <= W;
            m_pend   <= 64'(bus.a) * 64'(bus.b) + 64'(bus.c);
            m_busy   <= 1'b1;
            m_done   <= 1'b0;
        end else if (m_active && m_remain == 1) begin
            m_p      <= m_pend;
            m_done   <= 1'b1;
            m_busy   <= 1'b0;
            m_active <= 1'b0;
        end else begin
            if (m_active) m_remain <= m_remain - 1;
            m_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc busy", 64'(bus.busy), 64'(m_busy));
            check("cyc done", 64'(bus.done), 64'(m_done));
            check("cyc p", {bus.p_hi, bus.p_lo}, m_p);
        end
    end

    // Callers sit 2 time units after a rising edge; returns likewise.
    task automatic start(input logic [31:0] av, input logic [31:0] bv, input logic [31:0] cv);
        bus.en = 1'b1;
        bus.a  = av;
        bus.b  = bv;
        bus.c  = cv;
        @(posedge clk);
        #2;
        bus.en = 1'b0;
    endtask

    // Operands are scrambled while busy; only the start-edge values matter.
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                #1;
                break;
            end
            #1;
            bus.a = $urandom;
            bus.b = $urandom;
            bus.c = $urandom;
        end
    endtask

    task automatic op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] cv);
        int lat;
        start(av, bv, cv);
        wait_done(lat);
        check({nm, " latency"}, 64'(lat), 64'(W));
        check({nm, " result"}, {bus.p_hi, bus.p_lo}, 64'(av) * 64'(bv) + 64'(cv));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nd;
        logic [31:0] y, x, la, lb, lc;

        bus.en = 1'b0;
        bus.a  = '0;
        bus.b  = '0;
        bus.c  = '0;
        repeat (3) @(posedge clk);
        #2;
        check("reset p_hi", 64'(bus.p_hi), 64'd0);
        check("reset p_lo", 64'(bus.p_lo), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Basic operation and latency
        start(32'd3, 32'd5, 32'd7);
        check("t1 busy after en", 64'(bus.busy), 64'd1);
        wait_done(lat);
        check("t1 latency", 64'(lat), 64'd32);
        check("t1 p_hi", 64'(bus.p_hi), 64'd0);
        check("t1 p_lo", 64'(bus.p_lo), 64'd22);
        @(posedge clk);
        #1;
        check("t1 done one cycle", 64'(bus.done), 64'd0);
        #1;

        // Extremes
        op("t2 max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t2 max p_hi", 64'(bus.p_hi), 64'hFFFF_FFFF);
        check("t2 max p_lo", 64'(bus.p_lo), 64'h0);
        op("t2 2^32", 32'h0001_0000, 32'h0001_0000, 32'd0);
        check("t2 2^32 p", {bus.p_hi, bus.p_lo}, 64'h1_0000_0000);

        // Divider inverse
        op("t3 div", 32'd142, 32'd7, 32'd6);
        check("t3 div p_lo", 64'(bus.p_lo), 64'd1000);
        for (int i = 0; i < 8; i++) begin
            y = $urandom;
            x = (i < 4) ? 32'($urandom_range(1, 65535)) : ($urandom | 32'd1);
            op("t3 rand div", y / x, x, y % x);
            check("t3 reconstruct y", {bus.p_hi, bus.p_lo}, 64'(y));
        end

        // b = 0 still takes the full count
        x = $urandom;
        y = $urandom;
        op("b0", x, 32'd0, y);
        check("b0 result is c", 64'(bus.p_lo), 64'(y));

        // Restart mid-operation
        start(32'd3, 32'd5, 32'd7);
        repeat (9) @(posedge clk);
        #2;
        start(32'd2, 32'd2, 32'd0);
        wait_done(lat);
        check("t4 latency from restart", 64'(lat), 64'd32);
        check("t4 p", {bus.p_hi, bus.p_lo}, 64'd4);

        // Restart on the final-iteration edge
        start(32'd11, 32'd13, 32'd17);
        repeat (31) @(posedge clk);
        #2;
        start(32'd2, 32'd3, 32'd4);
        check("final-edge restart done", 64'(bus.done), 64'd0);
        check("final-edge restart p held", {bus.p_hi, bus.p_lo}, 64'd4);
        wait_done(lat);
        check("final-edge restart latency", 64'(lat), 64'd32);
        check("final-edge restart p", {bus.p_hi, bus.p_lo}, 64'd10);

        // Asynchronous reset mid-operation
        start(32'd3, 32'd5, 32'd7);
        repeat (14) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 p_hi async", 64'(bus.p_hi), 64'd0);
        check("t5 p_lo async", 64'(bus.p_lo), 64'd0);
        check("t5 busy async", 64'(bus.busy), 64'd0);
        check("t5 done async", 64'(bus.done), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        nd = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) nd++;
            #1;
        end
        check("t5 no done after abort", 64'(nd), 64'd0);

        // en held high continuously
        bus.en = 1'b1;
        nd = 0;
        la = '0;
        lb = '0;
        lc = '0;
        for (int i = 0; i < 40; i++) begin
            la = $urandom;
            lb = $urandom;
            lc = $urandom;
            bus.a = la;
            bus.b = lb;
            bus.c = lc;
            @(posedge clk);
            #1;
            if (bus.done) nd++;
            #1;
        end
        bus.en = 1'b0;
        check("t6 no done while en held", 64'(nd), 64'd0);
        wait_done(lat);
        check("t6 latency", 64'(lat), 64'd32);
        check("t6 p last operands", {bus.p_hi, bus.p_lo}, 64'(la) * 64'(lb) + 64'(lc));

        // Random traffic, checked every cycle against the model
        for (int i = 0; i < 1500; i++) begin
            bus.en = ($urandom_range(0, 29) == 0);
            bus.a  = $urandom;
            bus.b  = $urandom;
            bus.c  = $urandom;
            case ($urandom_range(0, 7))
                0: bus.b = '0;
                1: begin bus.a = '1; bus.b = '1; bus.c = '1; end
                2: bus.a = '0;
                default: ;
            endcase
            @(posedge clk);
            #2;
        end
        bus.en = 1'b0;
        repeat (40) @(posedge clk);
        #6;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_mul_add
`default_nettype wire

// File: doc/mul_add.md
Name: mul_add

Overview:
- Sequential unsigned multiply-accumulate: computes P = a*b + c, with 32-bit operands and a 64-bit result.
- Radix-2 shift-add, one multiplier bit per cycle.
- Inverse of the divider: feeding {q, x, r} reconstructs y.
- Serves as the LCG state-update engine in the PRNG: next = a*state + c, with the modulus taken from p_lo.

Parameters:
WIDTH, 32, operand width; result is 2*WIDTH bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst_n  in  1  reset, asynchronous, active-low.
en  in  1  start strobe; a, b, c are sampled on the edge where en=1.
a  in  WIDTH  multiplicand.
b  in  WIDTH  multiplier.
c  in  WIDTH  addend.
p_hi  out  WIDTH  result bits [2W-1:W], registered.
p_lo  out  WIDTH  result bits [W-1:0], registered.
busy  out  1  high while an operation is in progress.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; p_hi=0, p_lo=0, done=0, busy=0; internal acc/mcand/mplier/cnt cleared.
  - Takes effect immediately, mid-operation included; the operation is aborted.
  - No done is ever produced for an aborted operation.
- Internal registers: acc[2W], mcand[2W], mplier[W], cnt[CNT_W].
- States: IDLE, RUN.
- Edge with en=1 (any state, highest priority after reset):
  - acc<=zero-extended c; mcand<=zero-extended a; mplier<=b; cnt<=0; state<=RUN; busy<=1; done<=0.
  - p_hi/p_lo hold their previous values.
- RUN, en=0, each edge:
  - if mplier[0], acc<=acc+mcand (2W-bit add, no carry out possible);
  - mcand<=mcand<<1; mplier<=mplier>>1; cnt<=cnt+1.
- Final iteration, on the edge where cnt==WIDTH-1:
  - {p_hi,p_lo}<=acc_next, the sum including this iteration's add;
  - done<=1; busy<=0; state<=IDLE.
- Latency:
  - done and the new result are visible after exactly WIDTH rising edges following the edge that sampled en (32 for the default).
  - The loop runs a fixed count; there is no early exit when mplier becomes 0.
- done is high for exactly one cycle and clears on the next edge unless that edge completes another operation (impossible for WIDTH>1).
- IDLE, en=0: all registers hold; done<=0.
- Results p_hi/p_lo hold until the next completion or reset.
- Overflow: max result (2^W-1)^2 + 2^W-1 = 2^2W - 2^W fits in 2W bits; no wrap case exists.
- Boundary conditions:
  - en asserted during RUN: the operation restarts with the new operands and the old operation is discarded (no done).
  - en on the same edge as the final iteration: restart wins; done stays 0 and p keeps its old value.
  - en held high continuously: the block reloads every edge and never completes.
  - b=0: still WIDTH cycles; result = c.
  - Operands change while busy: ignored, since only the values at the en edge matter.

Decomposition:
- Package mul_add_pkg: state enum {IDLE, RUN}; default WIDTH and CNT_W constants.
- Single module; no sub-module needed. The add/shift step is kept inline in the sequential process.

Test Plan:
1. a=3, b=5, c=7, en pulse -> busy=1 next cycle; done=1 exactly 32 edges later with p_hi=0, p_lo=22; done low the following cycle.
2. a=b=c=0xFFFFFFFF -> p_hi=0xFFFFFFFF, p_lo=0x00000000; a=0x00010000, b=0x00010000, c=0 -> p_hi=1, p_lo=0.
3. Divider inverse: a=142, b=7, c=6 -> p_lo=1000 (0x3E8), p_hi=0; randomized {y,x} through the divider then {q,x,r} here -> p_lo==y.
4. Start a=3, b=5, c=7; at edge 10 pulse en with a=2, b=2, c=0 -> single done, 32 edges after the second en, p_lo=4; no done at edge 32 of the first operation.
5. rst_n low asynchronously at cycle 15 of an operation -> p_hi=p_lo=0, busy=0, done=0 before the next edge; after release, no done without a new en.
6. en held high 40 cycles -> done never asserts; drop en -> done exactly 32 edges after the last en edge, result uses the operands from that edge.
